// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared types for the memory-stage data responder:
//   - store/access size encoding (matches the sel field of the request)
//   - responder FSM state encoding
//   - byte-lane count of the doubleword datapath
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int DMR_DATA_W = 64;
  localparam int DMR_LANES  = DMR_DATA_W / 8;

  typedef enum logic [1:0] {
    BYTE   = 2'b00,
    HALF   = 2'b01,
    WORD   = 2'b10,
    DOUBLE = 2'b11
  } store_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ACK  = 2'b10
  } dmr_state_e;

endpackage

// File: rtl/riscv_dmr_lanegen.sv
// -----------------------------------------------------------------------------
// riscv_dmr_lanegen
// Combinational byte-lane generator for the data responder.
// Ports:
//   sel_i     - access size (BYTE/HALF/WORD/DOUBLE)
//   off_i     - byte offset inside the doubleword
//   wdata_i   - right-justified store data
//   be_o      - byte enables (size mask shifted to the offset)
//   wdata_o   - store data moved onto its byte lanes
//   aligned_o - high when the access is naturally aligned for its size
// -----------------------------------------------------------------------------
module riscv_dmr_lanegen
  import riscv_pkg::*;
#(
  parameter int DATA_W = DMR_DATA_W
) (
  input  logic [1:0]          sel_i,
  input  logic [2:0]          off_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W/8-1:0] be_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic                aligned_o
);

  localparam int LANES = DATA_W / 8;

  logic [LANES-1:0] size_mask;

  always_comb begin
    size_mask = '0;
    aligned_o = 1'b1;
    case (sel_i)
      BYTE: begin
        size_mask = LANES'(1);
        aligned_o = 1'b1;
      end
      HALF: begin
        size_mask = LANES'(3);
        aligned_o = ~off_i[0];
      end
      WORD: begin
        size_mask = LANES'(15);
        aligned_o = (off_i[1:0] == 2'b00);
      end
      DOUBLE: begin
        size_mask = LANES'(255);
        aligned_o = (off_i == 3'b000);
      end
      default: begin
        size_mask = '0;
        aligned_o = 1'b1;
      end
    endcase
  end

  // Lanes shifted past the top are dropped; that only happens on misaligned
  // accesses, which never write.
  assign be_o    = size_mask << off_i;
  assign wdata_o = wdata_i << {off_i, 3'b000};

endmodule

// File: rtl/riscv_dmem_resp.sv
// -----------------------------------------------------------------------------
// riscv_dmem_resp
// Multi-cycle handshaked data-memory responder for the memory stage.
// Ports:
//   i_riscv_dmr_clk      - clock
//   i_riscv_dmr_rst      - synchronous active-high reset (clears the array)
//   i_riscv_dmr_req      - request valid, held until ack (drop in WAIT aborts)
//   i_riscv_dmr_wen      - 1 = store, 0 = load
//   i_riscv_dmr_sel      - access size (byte/half/word/double)
//   i_riscv_dmr_addr     - byte address; index wraps modulo DEPTH
//   i_riscv_dmr_wdata    - right-justified store data
//   o_riscv_dmr_rdata    - doubleword at the index before this request's write
//   o_riscv_dmr_ack      - one-cycle completion pulse, LATENCY cycles after accept
//   o_riscv_dmr_stall    - req & ~ack, to the hazard unit
//   o_riscv_dmr_misalign - valid with ack; access was misaligned (no write)
// -----------------------------------------------------------------------------
module riscv_dmem_resp
  import riscv_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              i_riscv_dmr_clk,
  input  logic              i_riscv_dmr_rst,
  input  logic              i_riscv_dmr_req,
  input  logic              i_riscv_dmr_wen,
  input  logic [1:0]        i_riscv_dmr_sel,
  input  logic [ADDR_W-1:0] i_riscv_dmr_addr,
  input  logic [DATA_W-1:0] i_riscv_dmr_wdata,
  output logic [DATA_W-1:0] o_riscv_dmr_rdata,
  output logic              o_riscv_dmr_ack,
  output logic              o_riscv_dmr_stall,
  output logic              o_riscv_dmr_misalign
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LANES = DATA_W / 8;
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  dmr_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept;

  // Latched request; only index+offset bits of the address are kept.
  logic              wen_q;
  logic [1:0]        sel_q;
  logic [IDX_W+2:0]  addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] rdata_q;
  logic              misalign_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // In IDLE the live request is used so a LATENCY=1 access can enter ACK on
  // the same edge that latches it; afterwards the latched copy is used.
  logic              in_idle;
  logic [1:0]        cur_sel;
  logic [IDX_W+2:0]  cur_addr;
  logic [IDX_W-1:0]  cur_idx;
  logic [2:0]        cur_off;
  logic [LANES-1:0]  lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic              aligned;
  logic              enter_ack;
  logic              commit;

  logic unused_addr_bits;
  assign unused_addr_bits = ^i_riscv_dmr_addr[ADDR_W-1:IDX_W+3];

  assign in_idle  = (state_q == IDLE);
  assign cur_sel  = in_idle ? i_riscv_dmr_sel : sel_q;
  assign cur_addr = in_idle ? i_riscv_dmr_addr[IDX_W+2:0] : addr_q;
  assign cur_idx  = cur_addr[IDX_W+2:3];
  assign cur_off  = cur_addr[2:0];

  riscv_dmr_lanegen #(
    .DATA_W (DATA_W)
  ) u_lanegen (
    .sel_i     (cur_sel),
    .off_i     (cur_off),
    .wdata_i   (wdata_q),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .aligned_o (aligned)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_riscv_dmr_req) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = ACK;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        // Dropping req here is a pipeline flush: abandon without ack/write.
        if (!i_riscv_dmr_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign enter_ack = (state_d == ACK) && (state_q != ACK);
  assign commit    = (state_q == ACK) && wen_q && aligned;

  always_ff @(posedge i_riscv_dmr_clk) begin
    if (i_riscv_dmr_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wen_q      <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wen_q   <= i_riscv_dmr_wen;
        sel_q   <= i_riscv_dmr_sel;
        addr_q  <= i_riscv_dmr_addr[IDX_W+2:0];
        wdata_q <= i_riscv_dmr_wdata;
      end
      // Read happens before the commit edge, so stores return the old value.
      if (enter_ack) begin
        rdata_q    <= mem_q[cur_idx];
        misalign_q <= ~aligned;
      end
    end
  end

  always_ff @(posedge i_riscv_dmr_clk) begin
    if (i_riscv_dmr_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_be[l]) begin
          mem_q[cur_idx][8*l +: 8] <= lane_wdata[8*l +: 8];
        end
      end
    end
  end

  assign o_riscv_dmr_ack      = (state_q == ACK);
  assign o_riscv_dmr_stall    = i_riscv_dmr_req & ~o_riscv_dmr_ack;
  assign o_riscv_dmr_rdata    = rdata_q;
  assign o_riscv_dmr_misalign = misalign_q;

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// -----------------------------------------------------------------------------
// tb_riscv_dmem_resp
// Directed plus randomized requests against a behavioural memory model.
// -----------------------------------------------------------------------------
module tb_riscv_dmem_resp;

  localparam int LAT   = 4;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wen;
  logic [1:0]  sel;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        ack;
  logic        stall;
  logic        misalign;

  always #5 clk = ~clk;

  riscv_dmem_resp #(
    .DATA_W  (64),
    .ADDR_W  (64),
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .i_riscv_dmr_clk      (clk),
    .i_riscv_dmr_rst      (rst),
    .i_riscv_dmr_req      (req),
    .i_riscv_dmr_wen      (wen),
    .i_riscv_dmr_sel      (sel),
    .i_riscv_dmr_addr     (addr),
    .i_riscv_dmr_wdata    (wdata),
    .o_riscv_dmr_rdata    (rdata),
    .o_riscv_dmr_ack      (ack),
    .o_riscv_dmr_stall    (stall),
    .o_riscv_dmr_misalign (misalign)
  );

  logic [63:0] mem_m [DEPTH];
  logic [63:0] last_rdata;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_aligned(input logic [1:0] s, input logic [63:0] a);
    int size;
    size = 1 << s;
    return (int'(a[2:0]) % size) == 0;
  endfunction

  function automatic int model_idx(input logic [63:0] a);
    return int'((a / 64'd8) % 64'(DEPTH));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask

  // Entry and exit: one time unit after a rising edge.
  task automatic do_req(input bit w, input logic [1:0] s, input logic [63:0] a, input logic [63:0] d);
    logic [63:0] exp_rd;
    bit          exp_mis;
    bit          got_ack;
    int          idx;
    int          k;
    int          sz;
    int          off;
    idx     = model_idx(a);
    exp_rd  = mem_m[idx];
    exp_mis = !model_aligned(s, a);
    req = 1'b1; wen = w; sel = s; addr = a; wdata = d;
    got_ack = 1'b0;
    for (k = 0; k <= LAT + 3; k++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        got_ack = 1'b1;
        break;
      end
      check_val("stall_pending", {63'd0, stall}, 64'd1);
      @(posedge clk); #1;
      // Fields after acceptance must be ignored by the responder.
      wen   = $urandom_range(0, 1);
      sel   = 2'($urandom_range(0, 3));
      addr  = {$urandom, $urandom};
      wdata = {$urandom, $urandom};
    end
    check_val("ack_latency", 64'(k), 64'(LAT));
    if (got_ack) begin
      check_val("rdata", rdata, exp_rd);
      check_val("misalign", {63'd0, misalign}, {63'd0, exp_mis});
      check_val("stall_at_ack", {63'd0, stall}, 64'd0);
      last_rdata = rdata;
      if (w && !exp_mis) begin
        sz  = 1 << s;
        off = int'(a[2:0]);
        for (int b = 0; b < sz; b++) mem_m[idx][8*(off+b) +: 8] = d[8*b +: 8];
      end
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      check_val("ack_single", {63'd0, ack}, 64'd0);
      check_val("rdata_hold", rdata, exp_rd);
      @(posedge clk); #1;
    end else begin
      req = 1'b0;
      @(posedge clk); #1;
    end
    $display("TXN %s sel=%0d addr=%h wdata=%h rdata=%h misalign=%0b", w ? "ST" : "LD", s, a, d,
             last_rdata, exp_mis);
  endtask

  // Store double that is flushed in WAIT after 'drop' cycles.
  task automatic do_abort(input logic [63:0] a, input logic [63:0] d, input int drop);
    req = 1'b1; wen = 1'b1; sel = 2'b11; addr = a; wdata = d;
    for (int k = 0; k < drop; k++) begin
      @(negedge clk);
      check_val("abort_noack", {63'd0, ack}, 64'd0);
      check_val("abort_stall", {63'd0, stall}, 64'd1);
      @(posedge clk); #1;
    end
    req = 1'b0;
    @(negedge clk);
    check_val("abort_drop_ack", {63'd0, ack}, 64'd0);
    check_val("abort_drop_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    $display("TXN ABORT addr=%h wdata=%h drop_cycle=%0d", a, d, drop);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] ra;
    rst = 1'b1; req = 1'b0; wen = 1'b0; sel = 2'b00; addr = '0; wdata = '0;
    last_rdata = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("reset_ack", {63'd0, ack}, 64'd0);
    check_val("reset_rdata", rdata, 64'd0);
    check_val("reset_misalign", {63'd0, misalign}, 64'd0);
    check_val("reset_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;

    do_req(1'b0, 2'b11, 64'h40, 64'h0);
    do_req(1'b1, 2'b11, 64'h08, 64'h1122334455667788);
    check_val("store_old_value", last_rdata, 64'h0);
    do_req(1'b0, 2'b11, 64'h08, 64'h0);
    check_val("plan_double", last_rdata, 64'h1122334455667788);
    do_req(1'b1, 2'b00, 64'h0B, 64'hAB);
    do_req(1'b0, 2'b11, 64'h08, 64'h0);
    check_val("plan_byte", last_rdata, 64'h11223344AB667788);
    do_req(1'b1, 2'b10, 64'h0A, 64'hDEADBEEF);
    do_req(1'b0, 2'b11, 64'h08, 64'h0);
    check_val("plan_misaligned", last_rdata, 64'h11223344AB667788);

    do_abort(64'h10, 64'hCAFEF00D12345678, 2);
    do_req(1'b0, 2'b11, 64'h10, 64'h0);
    check_val("plan_abort", last_rdata, 64'h0);

    do_req(1'b1, 2'b11, 64'h2008, 64'h0102030405060708);
    do_req(1'b0, 2'b11, 64'h0008, 64'h0);
    check_val("plan_alias", last_rdata, 64'h0102030405060708);

    // Reset while a store sits in WAIT: no write, outputs cleared.
    do_req(1'b1, 2'b11, 64'h18, 64'h5555AAAA5555AAAA);
    do_req(1'b0, 2'b11, 64'h18, 64'h0);
    req = 1'b1; wen = 1'b1; sel = 2'b11; addr = 64'h18; wdata = 64'h9999888877776666;
    @(posedge clk); #1;
    rst = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    model_clear();
    @(negedge clk);
    check_val("rst_wait_ack", {63'd0, ack}, 64'd0);
    check_val("rst_wait_rdata", rdata, 64'd0);
    check_val("rst_wait_misalign", {63'd0, misalign}, 64'd0);
    check_val("rst_wait_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_req(1'b0, 2'b11, 64'h18, 64'h0);
    check_val("rst_cleared", last_rdata, 64'h0);

    for (int t = 0; t < 80; t++) begin
      ra = {$urandom, $urandom};
      ra[12:3] = 10'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 12) begin
        ra[2:0] = 3'b000;
        do_abort(ra, {$urandom, $urandom}, $urandom_range(1, LAT - 1));
      end else begin
        do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, {$urandom, $urandom});
      end
    end
    for (int i = 0; i < 8; i++) do_req(1'b0, 2'b11, 64'(i * 8), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_resp.md
Name: riscv_dmem_resp

Overview:
- Responder end of the memory-stage data interface. The datapath issues load/store requests; this block serves them.
- Replaces the zero-latency data memory with a multi-cycle, handshaked responder that has a fixed configurable latency.
- Owns the data storage array, applies store byte lanes, checks alignment, and drives a stall toward the hazard unit until each request completes.

Parameters:
- DATA_W, 64, data and doubleword width.
- ADDR_W, 64, request address width.
- DEPTH, 1024, number of doubleword entries; must be a power of two.
- LATENCY, 2, cycles from request acceptance to ack; legal range 1..15.

Ports:
- i_riscv_dmr_clk, in, 1, clock.
- i_riscv_dmr_rst, in, 1, synchronous active-high reset.
- i_riscv_dmr_req, in, 1, request valid from memory stage.
- i_riscv_dmr_wen, in, 1, 1=store, 0=load.
- i_riscv_dmr_sel, in, 2, store size: 00=byte, 01=half, 10=word, 11=double.
- i_riscv_dmr_addr, in, ADDR_W, byte address.
- i_riscv_dmr_wdata, in, DATA_W, store data, right-justified.
- o_riscv_dmr_rdata, out, DATA_W, aligned doubleword at the request index; sign/zero extension is done in the datapath.
- o_riscv_dmr_ack, out, 1, one-cycle completion pulse.
- o_riscv_dmr_stall, out, 1, to hazard unit; equals req & ~ack (combinational).
- o_riscv_dmr_misalign, out, 1, valid with ack; high when the access is misaligned.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, cnt=0.
  - ack=0, rdata=0, misalign=0.
  - All array entries cleared to 0.
  - Reset mid-operation aborts the request; no write occurs.
- Address decode:
  - index = addr[$clog2(DEPTH)+2:3]; upper bits are ignored, so the index wraps modulo DEPTH.
  - off = addr[2:0].
- Alignment:
  - byte: always aligned.
  - half: off[0]=0.
  - word: off[1:0]=0.
  - double: off=0.
  - Loads are checked with the same rule using sel.
- FSM states IDLE, WAIT, ACK:
  - IDLE & req: latch wen, sel, addr, wdata. If LATENCY=1, go to ACK. Otherwise go to WAIT with cnt=LATENCY-2.
  - WAIT: if cnt!=0, decrement. If cnt==0, go to ACK.
  - ACK: ack=1 for exactly this cycle, then go to IDLE unconditionally.
- Latency: req first seen in IDLE at cycle 0 gives ack high in cycle LATENCY. After ack, at least one IDLE cycle follows before the next request is accepted.
- rdata and misalign:
  - Registered on the edge entering ACK.
  - rdata = array[index] before any write of this request, for both loads and stores.
  - Held stable after ACK until the next ACK or reset.
- Store commit:
  - Happens on the clock edge that ends the ACK cycle, and only if aligned.
  - Byte enables = size mask shifted left by off.
  - Lane data = wdata << (8*off).
  - Unenabled bytes are preserved.
  - A misaligned store writes nothing and raises misalign with ack.
- Requester rule: req and its fields stay stable until ack. Fields changing mid-request are ignored, since the latched copy is used.
- Abort: req deasserted while in WAIT (pipeline flush) returns the FSM to IDLE next cycle with no ack and no write. req deasserted during ACK has no effect; the write still commits.
- Array: single read/write port.

Decomposition:
- Shared package riscv_pkg holds:
  - enum for store size (BYTE, HALF, WORD, DOUBLE) matching the sel encoding;
  - enum for dmr_state (IDLE, WAIT, ACK);
  - constant for byte-lane count (DATA_W/8).
- Sub-module riscv_dmr_lanegen: combinational. Inputs sel and off; outputs the 8-bit byte-enable, shifted write data, and the aligned flag.

Test Plan:
- Reset, then load addr 0x40 with LATENCY=2: stall high in cycles 0–1; ack in cycle 2; rdata=0; misalign=0.
- Store double 0x1122334455667788 at 0x08, then load 0x08: load returns 0x1122334455667788. The store's own rdata shows the prior value 0.
- Store byte 0xAB at 0x0B over that value, then load 0x08: rdata=0x11223344AB667788 (lane 3 replaced, others intact).
- Store word at 0x0A (misaligned): ack with misalign=1. Subsequent load 0x08 shows no change.
- Request to 0x10, drop req in WAIT (LATENCY=4): no ack, array unchanged. FSM is IDLE next cycle, and a new request completes in 4 cycles.
- Address 0x2008 with DEPTH=1024 aliases index 1 (0x0008). Assert reset during WAIT of a store: no write, all outputs 0 next cycle.
